// File: rtl/nonogram_solver.sv
// nonogram_solver
//   Streaming line-deduction engine for a nonogram board of up to
//   MAX_ROWS x MAX_COLS cells. An upstream FIFO supplies, per line, a line
//   index word followed by that line's candidate fill patterns. Candidates
//   that contradict known cells are dropped. Cells on which every surviving
//   candidate agrees become known when the line's last candidate is consumed.
//
// Ports
//   clk              clock
//   rst              synchronous active-low reset
//   started          option carries a valid word this cycle
//   option           line index word (INDEX) or candidate pattern (OPTION)
//   num_rows         active rows
//   num_cols         active columns
//   old_options_amnt candidate count per line, sampled with the index word
//   new_line         next word is expected to be a line index
//   put_back_to_FIFO current candidate should be re-queued
//   assigned         cell values, meaningful where known=1
//   known            cell-resolved mask
//   conflict         (only with NONOGRAM_SOLVER_CONFLICT_EN) sticky flag,
//                    a line closed with no consistent candidate
//   solved           all active cells known (sticky)
//
// Optional feature macro: NONOGRAM_SOLVER_CONFLICT_EN
module nonogram_solver #(
    parameter int unsigned MAX_ROWS = 4,
    parameter int unsigned MAX_COLS = 4,
    localparam int unsigned W  = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
    localparam int unsigned L  = MAX_ROWS + MAX_COLS,
    localparam int unsigned RW = $clog2(MAX_ROWS + 1),
    localparam int unsigned CW = $clog2(MAX_COLS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               started,
    input  logic [W-1:0]                       option,
    input  logic [RW-1:0]                      num_rows,
    input  logic [CW-1:0]                      num_cols,
    input  logic [L-1:0][6:0]                  old_options_amnt,
    output logic                               new_line,
    output logic                               put_back_to_FIFO,
    output logic [MAX_ROWS-1:0][MAX_COLS-1:0]  assigned,
    output logic [MAX_ROWS-1:0][MAX_COLS-1:0]  known,
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
    output logic                               conflict,
`endif
    output logic                               solved
);

    typedef enum logic {INDEX, OPTION} state_t;

    state_t         state;
    logic           is_row;
    logic [W-1:0]   line_no;
    logic [W-1:0]   n_len;
    logic [6:0]     remaining;
    logic [W-1:0]   ones_acc;
    logic [W-1:0]   zeros_acc;
    logic           any_ok;

    // index decode
    logic [W:0]     idx_ext;
    logic [W:0]     rows_ext;
    logic [W:0]     lines_ext;
    logic           idx_is_row;
    logic           idx_in_range;
    logic [6:0]     idx_count;

    // candidate evaluation, all vectors in cell order (bit k = cell k)
    logic [W-1:0]   rev;
    logic [W:0]     shift_amt;
    logic [W-1:0]   cand;
    logic [W-1:0]   line_mask;
    logic [W-1:0]   line_known;
    logic [W-1:0]   line_asg;
    logic           all_known;
    logic           consistent;
    logic           last_word;
    logic [W-1:0]   ones_next;
    logic [W-1:0]   zeros_next;
    logic           any_next;
    logic [W-1:0]   resolved;
    logic           line_full;
    logic           commit;

    logic [MAX_ROWS-1:0][MAX_COLS-1:0] cell_upd;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0] cell_val;

    always_comb begin
        idx_ext      = {1'b0, option};
        rows_ext     = (W+1)'(num_rows);
        lines_ext    = rows_ext + (W+1)'(num_cols);
        idx_is_row   = idx_ext < rows_ext;
        idx_in_range = idx_ext < lines_ext;
        idx_count    = '0;
        for (int unsigned i = 0; i < L; i++) begin
            if (option == W'(i)) idx_count = old_options_amnt[i];
        end
    end

    // Cell k takes option[n-1-k]: bit-reverse the word, then shift down so
    // cell 0 lands at bit 0; bits past the line length fall off as zeros.
    always_comb begin
        for (int unsigned k = 0; k < W; k++) rev[k] = option[W-1-k];
        shift_amt = (W+1)'(W) - {1'b0, n_len};
        cand      = rev >> shift_amt;
        line_mask = ~({W{1'b1}} << n_len);
    end

    always_comb begin
        line_known = '0;
        line_asg   = '0;
        all_known  = 1'b1;
        for (int unsigned r = 0; r < MAX_ROWS; r++) begin
            for (int unsigned c = 0; c < MAX_COLS; c++) begin
                if (is_row && line_no == W'(r)) begin
                    line_known[c] = known[r][c];
                    line_asg[c]   = assigned[r][c];
                end
                if (!is_row && line_no == W'(c)) begin
                    line_known[r] = known[r][c];
                    line_asg[r]   = assigned[r][c];
                end
                if (RW'(r) < num_rows && CW'(c) < num_cols && !known[r][c])
                    all_known = 1'b0;
            end
        end
    end

    always_comb begin
        consistent = ((cand ^ line_asg) & line_known & line_mask) == '0;
        last_word  = remaining == 7'd1;
        ones_next  = consistent ? (ones_acc & cand)   : ones_acc;
        zeros_next = consistent ? (zeros_acc & ~cand) : zeros_acc;
        any_next   = any_ok | consistent;
        commit     = started && state == OPTION && last_word;
        // On the closing candidate the line counts as full if the pending
        // commit resolves every cell, so a candidate that settles its line
        // is not re-queued.
        resolved   = line_known |
                     ((last_word && any_next) ? (ones_next | zeros_next) : '0);
        line_full  = (resolved & line_mask) == line_mask;
        put_back_to_FIFO = started && state == OPTION && consistent && !line_full;
    end

    always_comb begin
        cell_upd = '0;
        cell_val = '0;
        for (int unsigned r = 0; r < MAX_ROWS; r++) begin
            for (int unsigned c = 0; c < MAX_COLS; c++) begin
                if (is_row && line_no == W'(r)) begin
                    cell_upd[r][c] = commit && any_next && line_mask[c] &&
                                     !known[r][c] && (ones_next[c] | zeros_next[c]);
                    cell_val[r][c] = ones_next[c];
                end
                if (!is_row && line_no == W'(c)) begin
                    cell_upd[r][c] = commit && any_next && line_mask[r] &&
                                     !known[r][c] && (ones_next[r] | zeros_next[r]);
                    cell_val[r][c] = ones_next[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INDEX;
            new_line  <= 1'b1;
            is_row    <= 1'b0;
            line_no   <= '0;
            n_len     <= '0;
            remaining <= '0;
            ones_acc  <= '1;
            zeros_acc <= '1;
            any_ok    <= 1'b0;
            known     <= '0;
            assigned  <= '0;
            solved    <= 1'b0;
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
            conflict  <= 1'b0;
`endif
        end else begin
            solved <= solved | all_known;
            for (int unsigned r = 0; r < MAX_ROWS; r++) begin
                for (int unsigned c = 0; c < MAX_COLS; c++) begin
                    if (cell_upd[r][c]) begin
                        known[r][c]    <= 1'b1;
                        assigned[r][c] <= cell_val[r][c];
                    end
                end
            end
            if (started) begin
                case (state)
                    INDEX: begin
                        remaining <= idx_count;
                        is_row    <= idx_is_row;
                        line_no   <= idx_is_row ? option : option - W'(num_rows);
                        n_len     <= idx_is_row ? W'(num_cols) : W'(num_rows);
                        ones_acc  <= '1;
                        zeros_acc <= '1;
                        any_ok    <= 1'b0;
                        if (idx_in_range && idx_count != '0) begin
                            state    <= OPTION;
                            new_line <= 1'b0;
                        end
                    end
                    OPTION: begin
                        remaining <= remaining - 7'd1;
                        ones_acc  <= ones_next;
                        zeros_acc <= zeros_next;
                        any_ok    <= any_next;
                        if (last_word) begin
                            state    <= INDEX;
                            new_line <= 1'b1;
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
                            if (!any_next) conflict <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state    <= INDEX;
                        new_line <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonogram_solver.sv
// tb_nonogram_solver
//   Directed and randomized stimulus for nonogram_solver against a
//   queue-based reference model of the line-deduction rules.
module tb_nonogram_solver;

    localparam int unsigned MR = 4;
    localparam int unsigned MC = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned L  = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  started;
    logic [W-1:0]          option;
    logic [2:0]            num_rows;
    logic [2:0]            num_cols;
    logic [L-1:0][6:0]     amnt;
    logic                  new_line;
    logic                  put_back;
    logic [MR-1:0][MC-1:0] assigned;
    logic [MR-1:0][MC-1:0] known;
    logic                  solved;
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
    logic                  conflict;
`endif

    nonogram_solver #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .clk              (clk),
        .rst              (rst),
        .started          (started),
        .option           (option),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .old_options_amnt (amnt),
        .new_line         (new_line),
        .put_back_to_FIFO (put_back),
        .assigned         (assigned),
        .known            (known),
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
        .conflict         (conflict),
`endif
        .solved           (solved)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  nr = 4;
    int  nc = 4;
    bit  mk[MR][MC];
    bit  ma[MR][MC];
    bit  m_solved;
    bit  m_conflict;
    bit  sol[MR][MC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cell_rc(input int idx, input int k, output int r, output int c);
        if (idx < nr) begin r = idx; c = k; end
        else begin r = k; c = idx - nr; end
    endtask

    function automatic bit opt_bit(input logic [3:0] o, input int n, input int k);
        logic [3:0] t;
        t = o;
        return t[n-1-k];
    endfunction

    function automatic bit model_all_known();
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                if (!mk[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    // all survivors share one value at cell k
    task automatic agree(input logic [3:0] q[$], input int n, input int k,
                         output bit ok, output bit val);
        ok  = q.size() > 0;
        val = 1'b0;
        if (ok) begin
            val = opt_bit(q[0], n, k);
            foreach (q[j]) if (opt_bit(q[j], n, k) != val) ok = 1'b0;
        end
    endtask

    task automatic check_board(input string tag);
        logic [MR-1:0][MC-1:0] ek;
        logic [MR-1:0][MC-1:0] ea;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) begin
                ek[r][c] = mk[r][c];
                ea[r][c] = ma[r][c];
            end
        check({tag, "_known"}, known, ek);
        check({tag, "_assigned"}, assigned, ea);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        started = 1'b0;
        option = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) begin
                mk[r][c] = 1'b0;
                ma[r][c] = 1'b0;
            end
        m_solved = 1'b0;
        m_conflict = 1'b0;
        #1;
        check_board("reset");
        check("reset_solved", solved, 0);
        check("reset_new_line", new_line, 1);
        check("reset_put_back", put_back, 0);
    endtask

    task automatic run_line(input int idx, input logic [3:0] opts[$]);
        int n, r, c, last;
        bit valid, cons, full, ok, val, nxt;
        logic [3:0] surv[$];
        logic [3:0] tmp[$];
        for (int i = 0; i < L; i++) amnt[i] = 7'($urandom_range(0, 127));
        if (idx < L) amnt[idx] = 7'(opts.size());
        @(negedge clk);
        started = 1'b1;
        option  = 4'(idx);
        #1;
        check("idx_new_line", new_line, 1);
        check("idx_put_back", put_back, 0);
        valid = (idx < nr + nc) && (opts.size() > 0);
        n = (idx < nr) ? nc : nr;
        last = opts.size() - 1;
        if (valid) begin
            foreach (opts[j]) begin
                @(negedge clk);
                option = opts[j];
                #1;
                cons = 1'b1;
                for (int k = 0; k < n; k++) begin
                    cell_rc(idx, k, r, c);
                    if (mk[r][c] && opt_bit(opts[j], n, k) != ma[r][c]) cons = 1'b0;
                end
                tmp = surv;
                if (cons) tmp.push_back(opts[j]);
                full = 1'b1;
                for (int k = 0; k < n; k++) begin
                    cell_rc(idx, k, r, c);
                    agree(tmp, n, k, ok, val);
                    if (!mk[r][c] && !(j == last && ok)) full = 1'b0;
                end
                check("opt_put_back", put_back, cons && !full);
                check("opt_new_line", new_line, 0);
                if (cons) surv.push_back(opts[j]);
            end
        end
        @(negedge clk);
        started = 1'b0;
        #1;
        check("end_new_line", new_line, 1);
        check("end_solved", solved, m_solved);
        if (valid && surv.size() == 0) m_conflict = 1'b1;
        if (valid) begin
            for (int k = 0; k < n; k++) begin
                cell_rc(idx, k, r, c);
                agree(surv, n, k, ok, val);
                if (!mk[r][c] && ok) begin
                    mk[r][c] = 1'b1;
                    ma[r][c] = val;
                end
            end
        end
        check_board("commit");
`ifdef NONOGRAM_SOLVER_CONFLICT_EN
        check("conflict", conflict, m_conflict);
`endif
        @(negedge clk);
        nxt = m_solved | model_all_known();
        #1;
        check("solved_next", solved, nxt);
        m_solved = nxt;
    endtask

    task automatic random_board(input int rows, input int cols, input int rounds);
        int order[$];
        int n, r, c, j, t;
        logic [3:0] tp, sw;
        logic [3:0] opts[$];
        nr = rows;
        nc = cols;
        num_rows = 3'(rows);
        num_cols = 3'(cols);
        do_reset();
        for (int rr = 0; rr < MR; rr++)
            for (int cc = 0; cc < MC; cc++) sol[rr][cc] = 1'($urandom_range(0, 1));
        for (int rd = 0; rd <= rounds; rd++) begin
            order.delete();
            for (int i = 0; i < nr + nc; i++) order.push_back(i);
            for (int i = order.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            foreach (order[i]) begin
                n = (order[i] < nr) ? nc : nr;
                tp = 4'($urandom_range(0, 15));
                for (int k = 0; k < n; k++) begin
                    cell_rc(order[i], k, r, c);
                    tp[n-1-k] = sol[r][c];
                end
                opts.delete();
                opts.push_back(tp);
                if (rd < rounds) begin
                    t = $urandom_range(0, 3);
                    for (int q = 0; q < t; q++) opts.push_back(4'($urandom_range(0, 15)));
                    for (int q = opts.size() - 1; q > 0; q--) begin
                        j = $urandom_range(0, q);
                        sw = opts[q]; opts[q] = opts[j]; opts[j] = sw;
                    end
                end
                run_line(order[i], opts);
                if ($urandom_range(0, 7) == 0) begin
                    opts.delete();
                    opts.push_back(4'b0101);
                    run_line($urandom_range(nr + nc, 15), opts);
                end
            end
        end
        check("board_solved", solved, 1);
    endtask

    initial begin
        logic [3:0] q[$];
        rst = 1'b1;
        started = 1'b0;
        option = '0;
        amnt = '0;
        num_rows = 3'd4;
        num_cols = 3'd4;
        do_reset();

        q = '{4'b1011};
        run_line(3, q);
        q = '{4'b0011, 4'b0110, 4'b1100};
        run_line(0, q);
        q = '{4'b1110, 4'b0111};
        run_line(4, q);
        q.delete();
        run_line(1, q);
        q = '{4'b0100};
        run_line(3, q);

        // reset in the middle of a line leaves no trace of it
        amnt[5] = 7'd2;
        @(negedge clk);
        started = 1'b1;
        option = 4'd5;
        @(negedge clk);
        option = 4'b1111;
        @(negedge clk);
        do_reset();

        random_board(4, 4, 4);
        do_reset();
        random_board(3, 2, 3);
        random_board(4, 4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
